// File: rtl/reg_pkg.sv
// Shared types and defaults for the 16-bit core register file and its scoreboard.
package reg_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned NREGS_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [WIDTH_DEFAULT-1:0] word_t;
    typedef logic [AW_DEFAULT-1:0]    regaddr_t;

    // Architectural zero register: never written, never marked busy.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/reg_file_sb_tracker.sv
// Pending-write scoreboard: busy vector, RAW/WAW stall generation and busy count.
module sb_tracker
    import reg_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic [AW-1:0] rdAddrA,
    input  logic          rdEnA,
    input  logic [AW-1:0] rdAddrB,
    input  logic          rdEnB,
    input  logic          issueEn,
    input  logic [AW-1:0] issueDst,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    output logic          stall,
    output logic [AW:0]   pendingCnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      pending_cnt_q, pending_cnt_d;

    logic wr_hit_a, wr_hit_b, wr_hit_dst;
    logic haz_a, haz_b, waw;
    logic dst_nonzero, issue_ok, set_fire, set_eff, clear_eff;

    // Hazard detection; a writeback landing this cycle resolves the hazard via bypass.
    always_comb begin
        wr_hit_a    = wrEn && (wrAddr == rdAddrA);
        wr_hit_b    = wrEn && (wrAddr == rdAddrB);
        wr_hit_dst  = wrEn && (wrAddr == issueDst);
        dst_nonzero = (issueDst != AW'(ZERO_REG));

        haz_a = rdEnA && busy_q[rdAddrA] && !wr_hit_a;
        haz_b = rdEnB && busy_q[rdAddrB] && !wr_hit_b;
        waw   = issueEn && dst_nonzero && busy_q[issueDst] && !wr_hit_dst;

        stall    = issueEn && (haz_a || haz_b || waw);
        issue_ok = issueEn && !stall;
        set_fire = issue_ok && dst_nonzero;
    end

    // Next busy vector: clear from writeback first, then set from issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (wrEn) begin
            busy_d[wrAddr] = 1'b0;
        end
        if (set_fire) begin
            busy_d[issueDst] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Incremental popcount: a clear re-set in the same cycle and a set of a busy reg are no-ops.
    always_comb begin
        set_eff   = set_fire && !busy_q[issueDst];
        clear_eff = wrEn && busy_q[wrAddr] && !(set_fire && wr_hit_dst);

        pending_cnt_d = pending_cnt_q;
        unique case ({set_eff, clear_eff})
            2'b10:   pending_cnt_d = pending_cnt_q + (AW+1)'(1);
            2'b01:   pending_cnt_d = pending_cnt_q - (AW+1)'(1);
            default: pending_cnt_d = pending_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign pendingCnt = pending_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with write-through bypass, R0 hardwired to zero,
// and an attached pending-write scoreboard driving the decode stall.
module reg_file_sb
    import reg_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEFAULT,
    parameter  int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [AW-1:0]    rdAddrA,
    input  logic             rdEnA,
    output logic [WIDTH-1:0] rdDataA,
    input  logic [AW-1:0]    rdAddrB,
    input  logic             rdEnB,
    output logic [WIDTH-1:0] rdDataB,
    input  logic             issueEn,
    input  logic [AW-1:0]    issueDst,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    output logic             stall,
    output logic [AW:0]      pendingCnt
);

    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("reg_file_sb: NREGS must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_ok;

    // Write port; writes addressed to R0 are dropped.
    always_comb begin
        regs_d = regs_q;
        wr_ok  = wrEn && (wrAddr != AW'(ZERO_REG));
        if (wr_ok) begin
            regs_d[wrAddr] = wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: R0 forces zero, otherwise same-cycle writeback bypasses storage.
    always_comb begin
        if (rdAddrA == AW'(ZERO_REG)) begin
            rdDataA = '0;
        end else if (wrEn && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end else begin
            rdDataA = regs_q[rdAddrA];
        end

        if (rdAddrB == AW'(ZERO_REG)) begin
            rdDataB = '0;
        end else if (wrEn && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end else begin
            rdDataB = regs_q[rdAddrB];
        end
    end

    sb_tracker #(
        .NREGS (NREGS)
    ) u_sb_tracker (
        .clk        (clk),
        .nReset     (nReset),
        .rdAddrA    (rdAddrA),
        .rdEnA      (rdEnA),
        .rdAddrB    (rdAddrB),
        .rdEnB      (rdEnB),
        .issueEn    (issueEn),
        .issueDst   (issueDst),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .stall      (stall),
        .pendingCnt (pendingCnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb: reads, bypass, R0, RAW/WAW stalls, clear+set, reset.
module tb_reg_file_sb;

    logic        clk;
    logic        nReset;
    logic [2:0]  rdAddrA, rdAddrB, issueDst, wrAddr;
    logic        rdEnA, rdEnB, issueEn, wrEn;
    logic [15:0] rdDataA, rdDataB, wrData;
    logic        stall;
    logic [3:0]  pendingCnt;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_sb dut (
        .clk        (clk),
        .nReset     (nReset),
        .rdAddrA    (rdAddrA),
        .rdEnA      (rdEnA),
        .rdDataA    (rdDataA),
        .rdAddrB    (rdAddrB),
        .rdEnB      (rdEnB),
        .rdDataB    (rdDataB),
        .issueEn    (issueEn),
        .issueDst   (issueDst),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .stall      (stall),
        .pendingCnt (pendingCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdEnA = 0; rdEnB = 0; issueEn = 0; issueDst = 0;
        wrEn = 0; wrAddr = 0; wrData = 16'h0000;
    endtask

    task automatic test_reset();
        idle();
        rdAddrA = 0; rdAddrB = 0;
        nReset = 0;
        tick(); tick();
        nReset = 1;
        rdAddrA = 3; rdAddrB = 7;
        #1;
        n_cmp++; if (rdDataA !== 16'h0000) begin n_err++; $display("FAIL reset_rdA: got %h want 0000", rdDataA); end
        n_cmp++; if (rdDataB !== 16'h0000) begin n_err++; $display("FAIL reset_rdB: got %h want 0000", rdDataB); end
        n_cmp++; if (pendingCnt !== 4'd0)  begin n_err++; $display("FAIL reset_cnt: got %0d want 0", pendingCnt); end
        n_cmp++; if (stall !== 1'b0)       begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    endtask

    task automatic test_write_bypass();
        idle();
        wrEn = 1; wrAddr = 5; wrData = 16'hBEEF; rdAddrA = 5; rdAddrB = 3;
        #1;
        n_cmp++; if (rdDataA !== 16'hBEEF) begin n_err++; $display("FAIL bypass_rdA: got %h want BEEF", rdDataA); end
        n_cmp++; if (rdDataB !== 16'h0000) begin n_err++; $display("FAIL bypass_rdB_other: got %h want 0000", rdDataB); end
        tick();
        idle();
        rdAddrB = 5;
        #1;
        n_cmp++; if (rdDataA !== 16'hBEEF) begin n_err++; $display("FAIL stored_rdA: got %h want BEEF", rdDataA); end
        n_cmp++; if (rdDataB !== 16'hBEEF) begin n_err++; $display("FAIL stored_rdB: got %h want BEEF", rdDataB); end
        n_cmp++; if (pendingCnt !== 4'd0)  begin n_err++; $display("FAIL nonbusy_wr_cnt: got %0d want 0", pendingCnt); end
        wrEn = 1; wrAddr = 0; wrData = 16'h1234; rdAddrA = 0;
        #1;
        n_cmp++; if (rdDataA !== 16'h0000) begin n_err++; $display("FAIL r0_bypass: got %h want 0000", rdDataA); end
        tick();
        idle();
        #1;
        n_cmp++; if (rdDataA !== 16'h0000) begin n_err++; $display("FAIL r0_stored: got %h want 0000", rdDataA); end
        n_cmp++; if (rdDataB !== 16'hBEEF) begin n_err++; $display("FAIL r5_kept: got %h want BEEF", rdDataB); end
    endtask

    task automatic test_raw();
        idle();
        issueEn = 1; issueDst = 2;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_first_issue: got %b want 0", stall); end
        tick();
        issueDst = 3; rdEnA = 1; rdAddrA = 2;
        #1;
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL raw_stall: got %b want 1", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL raw_cnt: got %0d want 1", pendingCnt); end
        tick();
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL raw_stall_hold: got %b want 1", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL raw_cnt_hold: got %0d want 1", pendingCnt); end
        rdEnA = 0; rdEnB = 1; rdAddrB = 2;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_portB: got %b want 1", stall); end
        // Resolving writeback arrives; the stalled instruction (no destination) issues.
        rdEnA = 1; issueDst = 0;
        wrEn = 1; wrAddr = 2; wrData = 16'h00AA;
        #1;
        n_cmp++; if (stall !== 1'b0)       begin n_err++; $display("FAIL raw_release: got %b want 0", stall); end
        n_cmp++; if (rdDataA !== 16'h00AA) begin n_err++; $display("FAIL raw_bypass: got %h want 00AA", rdDataA); end
        tick();
        idle();
        #1;
        n_cmp++; if (pendingCnt !== 4'd0)  begin n_err++; $display("FAIL raw_cnt_after: got %0d want 0", pendingCnt); end
        n_cmp++; if (rdDataA !== 16'h00AA) begin n_err++; $display("FAIL raw_stored: got %h want 00AA", rdDataA); end
    endtask

    task automatic test_waw();
        idle();
        issueEn = 1; issueDst = 4;
        tick();
        #1;
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL waw_stall: got %b want 1", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL waw_cnt: got %0d want 1", pendingCnt); end
        tick();
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL waw_still_busy: got %b want 1", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL waw_cnt_hold: got %0d want 1", pendingCnt); end
        idle();
        wrEn = 1; wrAddr = 4; wrData = 16'h4444;
        tick();
        idle();
        #1;
        n_cmp++; if (pendingCnt !== 4'd0) begin n_err++; $display("FAIL waw_clear_cnt: got %0d want 0", pendingCnt); end
    endtask

    task automatic test_clear_set();
        idle();
        issueEn = 1; issueDst = 6;
        tick();
        issueDst = 6; wrEn = 1; wrAddr = 6; wrData = 16'h0606;
        #1;
        n_cmp++; if (stall !== 1'b0)      begin n_err++; $display("FAIL cs_stall: got %b want 0", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL cs_cnt_before: got %0d want 1", pendingCnt); end
        tick();
        idle();
        issueEn = 1; issueDst = 6;
        #1;
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL cs_still_busy: got %b want 1", stall); end
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL cs_cnt_after: got %0d want 1", pendingCnt); end
        // Clear R6 while setting R7: count unchanged.
        issueDst = 7; wrEn = 1; wrAddr = 6; wrData = 16'h6666;
        tick();
        idle();
        rdEnA = 1; rdAddrA = 6; rdEnB = 1; rdAddrB = 7; issueEn = 1; issueDst = 0;
        #1;
        n_cmp++; if (pendingCnt !== 4'd1) begin n_err++; $display("FAIL cs_diff_cnt: got %0d want 1", pendingCnt); end
        n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL cs_r7_busy: got %b want 1", stall); end
        rdEnB = 0;
        #1;
        n_cmp++; if (stall !== 1'b0)       begin n_err++; $display("FAIL cs_r6_free: got %b want 0", stall); end
        n_cmp++; if (rdDataA !== 16'h6666) begin n_err++; $display("FAIL cs_r6_data: got %h want 6666", rdDataA); end
        idle();
        wrEn = 1; wrAddr = 7; wrData = 16'h7777;
        tick();
        idle();
        #1;
        n_cmp++; if (pendingCnt !== 4'd0) begin n_err++; $display("FAIL cs_drain_cnt: got %0d want 0", pendingCnt); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        idle();
        for (int i = 1; i <= 3; i++) begin
            wrEn = 1; wrAddr = 3'(i); wrData = vals[i-1];
            issueEn = 1; issueDst = 3'(i);
            tick();
        end
        idle();
        rdAddrA = 1; rdAddrB = 3;
        #1;
        n_cmp++; if (pendingCnt !== 4'd3)  begin n_err++; $display("FAIL mid_cnt3: got %0d want 3", pendingCnt); end
        n_cmp++; if (rdDataA !== 16'h1111) begin n_err++; $display("FAIL mid_r1: got %h want 1111", rdDataA); end
        n_cmp++; if (rdDataB !== 16'h3333) begin n_err++; $display("FAIL mid_r3: got %h want 3333", rdDataB); end
        // Reset wins over a concurrent write and issue.
        nReset = 0;
        wrEn = 1; wrAddr = 1; wrData = 16'hFFFF; issueEn = 1; issueDst = 5;
        tick();
        nReset = 1;
        idle();
        #1;
        n_cmp++; if (pendingCnt !== 4'd0)  begin n_err++; $display("FAIL mid_cnt0: got %0d want 0", pendingCnt); end
        for (int i = 1; i <= 5; i++) begin
            rdAddrA = 3'(i);
            rdEnA = 1; issueEn = 1; issueDst = 0;
            #1;
            n_cmp++; if (rdDataA !== 16'h0000) begin n_err++; $display("FAIL mid_rd_r%0d: got %h want 0000", i, rdDataA); end
            n_cmp++; if (stall !== 1'b0)       begin n_err++; $display("FAIL mid_busy_r%0d: got %b want 0", i, stall); end
        end
        idle();
    endtask

    initial begin
        nReset = 0;
        rdAddrA = 0; rdAddrB = 0;
        idle();
        test_reset();
        test_write_bypass();
        test_raw();
        test_waw();
        test_clear_set();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- General-purpose register file for the 16-bit three-stage core: two combinational read ports and one synchronous write port.
- Includes a pending-write scoreboard. The decode stage reads operands and issues instructions; the writeback stage writes results.
- The scoreboard flags RAW/WAW hazards and produces a stall for the front of the pipeline.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 16, data bit-width of each register.
- NREGS, 8, number of architectural registers; must be a power of 2, ≥ 2.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- nReset  input  1  reset, synchronous, active-low.
- rdAddrA  input  AW  read port A address.
- rdEnA  input  1  port A operand used by the instruction being issued (hazard check only).
- rdDataA  output  WIDTH  port A data.
- rdAddrB  input  AW  read port B address.
- rdEnB  input  1  port B operand used (hazard check only).
- rdDataB  output  WIDTH  port B data.
- issueEn  input  1  decode requests issue of an instruction that writes issueDst.
- issueDst  input  AW  destination register of the issuing instruction.
- wrEn  input  1  writeback write strobe.
- wrAddr  input  AW  writeback destination.
- wrData  input  WIDTH  writeback data.
- stall  output  1  the issue cannot proceed this cycle.
- pendingCnt  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (sampled on clk rising edge while nReset=0):
  - all registers = 0, all busy bits = 0, pendingCnt = 0.
  - Reset overrides wrEn/issueEn in the same cycle.
  - Reset mid-operation discards all pending marks.
- Write:
  - At clk edge, if wrEn and wrAddr≠0: reg[wrAddr] ← wrData.
  - Writes to address 0 are ignored.
- Read (combinational, zero latency):
  - rdDataX = 0 if rdAddrX=0.
  - Else, if wrEn and wrAddr=rdAddrX, rdDataX = wrData (write-through bypass).
  - Else rdDataX = reg[rdAddrX].
  - rdEnX does not gate the data.
- Scoreboard (busy[NREGS]; busy[0] is constant 0):
  - hazA = rdEnA & busy[rdAddrA] & ~(wrEn & wrAddr=rdAddrA); hazB likewise.
  - waw = issueEn & issueDst≠0 & busy[issueDst] & ~(wrEn & wrAddr=issueDst).
  - stall = issueEn & (hazA | hazB | waw). Purely combinational; stall=0 when issueEn=0.
  - Issue accepted = issueEn & ~stall.
  - At clk edge, busy[wrAddr] is cleared if wrEn.
  - At clk edge, busy[issueDst] is set if the issue is accepted and issueDst≠0.
  - Same register cleared and set in the same cycle: set wins, so the register stays busy for the new writer.
  - wrEn to a non-busy register is legal; it writes data and busy stays 0.
- pendingCnt:
  - Registered; equals popcount(busy) after each edge.
  - Maintained incrementally: +1 on a set of a non-busy register, −1 on a clear without a set.
  - Net 0 when both happen to the same register or to different registers in one cycle.
  - Never exceeds NREGS−1.

Decomposition:
- Shared package (reg_pkg):
  - WIDTH and NREGS defaults.
  - typedef logic [WIDTH-1:0] word_t.
  - typedef logic [AW-1:0] regaddr_t.
  - constant ZERO_REG = 0.
- One natural sub-module, sb_tracker: holds the busy vector, the hazard/stall logic and pendingCnt.
- Storage and read muxes stay in the top level.

Test Plan:
1. Reset then reads:
   - Stimulus: nReset=0 for 2 cycles, then release; read A=3, B=7.
   - Response: rdData both 0; pendingCnt=0; stall=0.
2. Write/read with bypass and R0:
   - Stimulus: wrEn, wrAddr=5, wrData=16'hBEEF, with rdAddrA=5 in the same cycle.
   - Response: rdDataA=BEEF combinationally and on the next cycle.
   - Stimulus: wrAddr=0, wrData=16'h1234.
   - Response: a read of R0 stays 0.
3. RAW stall:
   - Stimulus: issue issueDst=2. Next cycle issue with rdEnA=1, rdAddrA=2.
   - Response: stall=1 and held while busy; pendingCnt=1.
   - Stimulus: wrEn wrAddr=2 data 16'h00AA.
   - Response: stall drops that same cycle, rdDataA=00AA; pendingCnt=0 after the edge.
4. WAW stall:
   - Stimulus: with R4 busy, issueEn issueDst=4, no writeback.
   - Response: stall=1, busy unchanged, pendingCnt unchanged.
5. Simultaneous clear and set:
   - Stimulus: R6 busy; same cycle wrEn wrAddr=6 and issue issueDst=6.
   - Response: stall=0; R6 still busy after the edge; pendingCnt unchanged.
6. Reset mid-operation:
   - Stimulus: R1, R2, R3 busy, pendingCnt=3; assert nReset=0 for 1 cycle.
   - Response: all busy cleared, pendingCnt=0, all registers read 0.
